iic_cfg_seq: RTL and testbench

//  Register-table configuration sequencer that drives one iic_dri instance. After a power-up delay it

---
 rtl/iic_cfg_seq_pkg.sv | 27 ++
 rtl/iic_cfg_seq_ms.sv | 44 ++++
 rtl/iic_cfg_seq.sv | 192 +++++++++++++++++++
 tb/tb_iic_cfg_seq.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/iic_cfg_seq_pkg.sv
// Shared definitions for the I2C register-table configuration sequencer:
// FSM encodings, table marker constants and the cycles-per-ms helper.
package iic_cfg_seq_pkg;

  localparam logic [3:0] S_PWR   = 4'd0;
  localparam logic [3:0] S_LOAD  = 4'd1;
  localparam logic [3:0] S_DLY   = 4'd2;
  localparam logic [3:0] S_TRIG  = 4'd3;
  localparam logic [3:0] S_WAITL = 4'd4;
  localparam logic [3:0] S_NEXT  = 4'd5;
  localparam logic [3:0] S_DONE  = 4'd6;
  localparam logic [3:0] S_ERR   = 4'd7;
  localparam logic [3:0] S_RTRIG = 4'd8;
  localparam logic [3:0] S_RWAIT = 4'd9;
  localparam logic [3:0] S_RCHK  = 4'd10;

  // Delay marker is all-ones in the address field, trimmed to ADDR_BYTE*8.
  localparam logic [15:0] DELAY_MARK = 16'hFFFF;
  localparam logic [15:0] END_MARK   = 16'h0000;

  localparam int MS_CNT_W = 27;

  function automatic int ms_div(input int clk_fre);
    return clk_fre / 1000;
  endfunction

endpackage

// File: rtl/iic_cfg_seq_ms.sv
// Millisecond delay timer: load a delay in ms, o_done is high on the last
// cycle of the delay. Product saturates so the 27-bit counter never wraps.
module iic_ms_timer
  import iic_cfg_seq_pkg::*;
#(
  parameter int MS_DIV = 50_000,
  parameter int MS_W   = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_load,
  input  logic [MS_W-1:0] i_ms,
  output logic            o_done
);

  localparam int PW = MS_W + MS_CNT_W;

  logic [MS_CNT_W-1:0] r_cnt;
  logic                r_run;
  logic [PW-1:0]       w_prod;
  logic [MS_CNT_W-1:0] w_cyc;

  assign w_prod = {{MS_CNT_W{1'b0}}, i_ms} * PW'(MS_DIV);
  assign w_cyc  = (|w_prod[PW-1:MS_CNT_W]) ? {MS_CNT_W{1'b1}} : w_prod[MS_CNT_W-1:0];
  assign o_done = r_run && (r_cnt <= MS_CNT_W'(1));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_load) begin
      r_cnt <= w_cyc;
      r_run <= 1'b1;
    end else if (r_run) begin
      if (r_cnt <= MS_CNT_W'(1)) begin
        r_cnt <= '0;
        r_run <= 1'b0;
      end else begin
        r_cnt <= r_cnt - MS_CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/iic_cfg_seq.sv
// Register-table configuration sequencer driving one iic_dri instance.
// Define IIC_CFG_READBACK_EN to read back and verify every written entry.
module iic_cfg_seq
  import iic_cfg_seq_pkg::*;
#(
  parameter int         CLK_FRE       = 50_000_000,
  parameter int         INIT_DELAY_MS = 20,
  parameter int         LUT_SIZE      = 256,
  parameter int         ADDR_BYTE     = 2,
  parameter logic [7:0] DEV_ID        = 8'h78,
  parameter int         BUSY_TO       = 4096
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_start,
  output logic [7:0]               o_lut_index,
  input  logic [ADDR_BYTE*8+7:0]   i_lut_data,
  output logic                     o_iic_pluse,
  output logic [7:0]               o_iic_device_id,
  output logic                     o_iic_w_r,
  output logic [3:0]               o_iic_byte_len,
  output logic [ADDR_BYTE*8-1:0]   o_iic_addr,
  output logic [7:0]               o_iic_data_in,
  input  logic                     i_iic_busy,
  input  logic [7:0]               i_iic_data_out,
  output logic                     o_cfg_done,
  output logic                     o_cfg_err,
  output logic [7:0]               o_err_index
);

  localparam int MS_DIV = ms_div(CLK_FRE);
  localparam int ADDR_W = ADDR_BYTE * 8;
  localparam int TO_W   = $clog2(BUSY_TO) + 1;

  logic [3:0]        r_state;
  logic [8:0]        r_idx;
  logic              r_ld_rdy;
  logic              r_armed;
  logic [TO_W-1:0]   r_tcnt;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_data;
  logic              r_wr;
  logic [7:0]        r_err_idx;
  logic              r_start_d;

  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_data;
  logic              w_start_rise;
  logic              w_at_end;
  logic              w_is_delay;
  logic              w_is_end;
  logic              w_tmr_load;
  logic [15:0]       w_tmr_ms;
  logic              w_tmr_done;

  assign w_addr       = i_lut_data[ADDR_W+7:8];
  assign w_data       = i_lut_data[7:0];
  assign w_start_rise = i_start & ~r_start_d;
  assign w_at_end     = (r_idx == 9'(LUT_SIZE));
  assign w_is_delay   = (w_addr == DELAY_MARK[ADDR_W-1:0]);
  assign w_is_end     = (w_addr == END_MARK[ADDR_W-1:0]) && (w_data == 8'h00);

  // Timer is shared: power-up delay while arming S_PWR, marker delay from S_LOAD.
  assign w_tmr_load = ((r_state == S_PWR) && !r_armed && !i_iic_busy) ||
                      ((r_state == S_LOAD) && r_ld_rdy && w_is_delay);
  assign w_tmr_ms   = (r_state == S_PWR) ? 16'(INIT_DELAY_MS) : 16'(w_data);

  iic_ms_timer #(.MS_DIV(MS_DIV), .MS_W(16)) u_tmr (
    .clk    (clk),
    .rstn   (rstn),
    .i_load (w_tmr_load),
    .i_ms   (w_tmr_ms),
    .o_done (w_tmr_done)
  );

`ifdef IIC_CFG_READBACK_EN
  logic w_rb_match;
  assign w_rb_match = (i_iic_data_out == r_data);
`else
  logic w_unused_rb;
  assign w_unused_rb = ^i_iic_data_out;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= S_PWR;
      r_idx     <= '0;
      r_ld_rdy  <= 1'b0;
      r_armed   <= 1'b0;
      r_tcnt    <= '0;
      r_addr    <= '0;
      r_data    <= '0;
      r_wr      <= 1'b1;
      r_err_idx <= '0;
      r_start_d <= 1'b0;
    end else begin
      r_start_d <= i_start;
      case (r_state)
        S_PWR: begin
          if (!r_armed) begin
            if (!i_iic_busy) r_armed <= 1'b1;
          end else if (w_tmr_done) begin
            r_armed  <= 1'b0;
            r_ld_rdy <= 1'b0;
            r_state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          // First cycle only lets the external ROM register the new index.
          if (!r_ld_rdy) begin
            if (w_at_end) r_state  <= S_DONE;
            else          r_ld_rdy <= 1'b1;
          end else begin
            r_ld_rdy <= 1'b0;
            r_addr   <= w_addr;
            r_data   <= w_data;
            if (w_is_delay) begin
              r_state <= S_DLY;
            end else if (w_is_end) begin
              r_state <= S_DONE;
            end else begin
              r_tcnt  <= '0;
              r_wr    <= 1'b1;
              r_state <= S_TRIG;
            end
          end
        end
        S_DLY: if (w_tmr_done) r_state <= S_NEXT;
        S_TRIG, S_RTRIG: begin
          // Keep pluse for at least 4 cycles so the driver's synchroniser sees it.
          if (i_iic_busy && (r_tcnt >= TO_W'(3))) begin
            r_state <= (r_state == S_RTRIG) ? S_RWAIT : S_WAITL;
          end else if (r_tcnt == TO_W'(BUSY_TO - 1)) begin
            r_err_idx <= o_lut_index;
            r_state   <= S_ERR;
          end else begin
            r_tcnt <= r_tcnt + TO_W'(1);
          end
        end
        S_WAITL: begin
          if (!i_iic_busy) begin
`ifdef IIC_CFG_READBACK_EN
            r_wr    <= 1'b0;
            r_tcnt  <= '0;
            r_state <= S_RTRIG;
`else
            r_state <= S_NEXT;
`endif
          end
        end
`ifdef IIC_CFG_READBACK_EN
        S_RWAIT: if (!i_iic_busy) r_state <= S_RCHK;
        S_RCHK: begin
          r_wr <= 1'b1;
          if (w_rb_match) begin
            r_state <= S_NEXT;
          end else begin
            r_err_idx <= o_lut_index;
            r_state   <= S_ERR;
          end
        end
`endif
        S_NEXT: begin
          if (!w_at_end) r_idx <= r_idx + 9'd1;
          r_ld_rdy <= 1'b0;
          r_state  <= S_LOAD;
        end
        S_DONE, S_ERR: begin
          if (w_start_rise) begin
            r_idx   <= '0;
            r_armed <= 1'b0;
            r_wr    <= 1'b1;
            r_state <= S_PWR;
          end
        end
        default: r_state <= S_PWR;
      endcase
    end
  end

  assign o_lut_index     = r_idx[8] ? 8'hFF : r_idx[7:0];
  assign o_iic_pluse     = (r_state == S_TRIG) || (r_state == S_RTRIG);
  assign o_iic_device_id = DEV_ID;
  assign o_iic_w_r       = r_wr;
  assign o_iic_byte_len  = 4'd1;
  assign o_iic_addr      = r_addr;
  assign o_iic_data_in   = r_data;
  assign o_cfg_done      = (r_state == S_DONE);
  assign o_cfg_err       = (r_state == S_ERR);
  assign o_err_index     = r_err_idx;

endmodule

// File: tb/tb_iic_cfg_seq.sv
// Bench for iic_cfg_seq with a behavioural iic_dri/slave model: table-driven
// LUT runs plus hand sequences for timeout, mid-frame reset and restart.
module tb_iic_cfg_seq;

  localparam int FRAME = 20;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  lut_index;
  logic [23:0] lut_data = '0;
  logic        pluse;
  logic [7:0]  dev_id;
  logic        w_r;
  logic [3:0]  byte_len;
  logic [15:0] iic_addr;
  logic [7:0]  data_in;
  logic        busy = 1'b0;
  logic [7:0]  data_out = '0;
  logic        done;
  logic        err;
  logic [7:0]  err_index;

  iic_cfg_seq #(
    .CLK_FRE(1_000_000), .INIT_DELAY_MS(1), .LUT_SIZE(4),
    .ADDR_BYTE(2), .DEV_ID(8'h78), .BUSY_TO(4096)
  ) dut (
    .clk(clk), .rstn(rstn), .i_start(start),
    .o_lut_index(lut_index), .i_lut_data(lut_data),
    .o_iic_pluse(pluse), .o_iic_device_id(dev_id), .o_iic_w_r(w_r),
    .o_iic_byte_len(byte_len), .o_iic_addr(iic_addr), .o_iic_data_in(data_in),
    .i_iic_busy(busy), .i_iic_data_out(data_out),
    .o_cfg_done(done), .o_cfg_err(err), .o_err_index(err_index)
  );

  always #5 clk = ~clk;

  // External registered LUT ROM
  logic [23:0] lut_mem [0:7];
  always @(posedge clk) lut_data <= lut_mem[lut_index[2:0]];

  // Driver + slave model
  int          cyc = 0;
  logic [3:0]  pl_sh = '0;
  int          fcnt = 0;
  bit          dead = 1'b0;
  bit          bad_en = 1'b0;
  logic [7:0]  smem [0:65535];
  logic [15:0] wq_addr[$];
  logic [7:0]  wq_data[$];
  int          rise_q[$];
  int          fall_q[$];
  int          rd_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    pl_sh <= {pl_sh[2:0], pluse};
    if (busy) begin
      fcnt <= fcnt - 1;
      if (fcnt <= 1) begin
        busy <= 1'b0;
        fall_q.push_back(cyc);
      end
    end else if (!dead && pl_sh[2] && !pl_sh[3]) begin
      busy <= 1'b1;
      fcnt <= FRAME;
      rise_q.push_back(cyc);
      if (w_r) begin
        wq_addr.push_back(iic_addr);
        wq_data.push_back(data_in);
        smem[iic_addr] <= data_in;
      end else begin
        rd_cnt   <= rd_cnt + 1;
        data_out <= (bad_en && iic_addr == 16'h3103) ? 8'h00 : smem[iic_addr];
      end
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_end(input string nm, input int budget);
    int n = 0;
    while (!(done || err) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_end_reached"}, 32'(done | err), 32'd1);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_idx"},    32'(lut_index), 32'h0);
    chk({nm, "_pluse"},  32'(pluse),     32'h0);
    chk({nm, "_wr"},     32'(w_r),       32'h1);
    chk({nm, "_addr"},   32'(iic_addr),  32'h0);
    chk({nm, "_data"},   32'(data_in),   32'h0);
    chk({nm, "_done"},   32'(done),      32'h0);
    chk({nm, "_err"},    32'(err),       32'h0);
    chk({nm, "_erridx"}, 32'(err_index), 32'h0);
  endtask

  task automatic load_lut(input logic [3:0][23:0] e);
    for (int i = 0; i < 8; i++) lut_mem[i] = (i < 4) ? e[i] : 24'hA5A5A5;
  endtask

  typedef struct {
    logic [3:0][23:0] e;
    int               nwr;
    logic [7:0]       idx;
    int               gap_min;
  } vec_t;

  function automatic vec_t mk(input logic [23:0] e0, e1, e2, e3,
                              input int nwr, input logic [7:0] idx, input int gap);
    vec_t v;
    v.e = {e3, e2, e1, e0};
    v.nwr = nwr;
    v.idx = idx;
    v.gap_min = gap;
    return v;
  endfunction

  task automatic run_case(input int ci, input vec_t v);
    int wb, fb, rb, t0, k, g, gmax;
    string p;
    p = $sformatf("v%0d", ci);
    load_lut(v.e);
    wb = wq_addr.size();
    fb = rise_q.size();
    rb = rd_cnt;
    do_reset();
    t0 = cyc;
    wait_end(p, 8000);
    @(negedge clk);
    chk({p, "_done"}, 32'(done), 32'h1);
    chk({p, "_err"},  32'(err),  32'h0);
    chk({p, "_idx"},  32'(lut_index), 32'(v.idx));
    chk({p, "_nwr"},  32'(wq_addr.size() - wb), 32'(v.nwr));
`ifdef IIC_CFG_READBACK_EN
    chk({p, "_nrd"},  32'(rd_cnt - rb), 32'(v.nwr));
`else
    chk({p, "_nrd"},  32'(rd_cnt - rb), 32'h0);
`endif
    // Expected write sequence: skip delay markers, stop at end marker
    k = wb;
    for (int i = 0; i < 4; i++) begin
      if (v.e[i][23:8] == 16'hFFFF) continue;
      if (v.e[i] == 24'h0) break;
      if (k < wq_addr.size()) begin
        chk($sformatf("%s_w%0d_addr", p, i), 32'(wq_addr[k]), 32'(v.e[i][23:8]));
        chk($sformatf("%s_w%0d_data", p, i), 32'(wq_data[k]), 32'(v.e[i][7:0]));
      end
      k++;
    end
    if (v.nwr > 0 && rise_q.size() > fb)
      chk({p, "_pwr_delay"}, 32'((rise_q[fb] - t0 >= 1000) && (rise_q[fb] - t0 <= 1100)), 32'h1);
    if (v.gap_min > 0) begin
      gmax = 0;
      for (int j = fb + 1; j < rise_q.size() && j - 1 < fall_q.size(); j++) begin
        g = rise_q[j] - fall_q[j-1];
        if (g > gmax) gmax = g;
      end
      chk({p, "_idle_gap"}, 32'(gmax >= v.gap_min), 32'h1);
    end
  endtask

  vec_t vecs[6];

  initial begin
    int tp, te, wb;
    vecs[0] = mk(24'h300882, 24'h310303, 24'h000000, 24'h000000, 2, 8'd2, 0);
    vecs[1] = mk(24'h300882, 24'hFFFF02, 24'h310303, 24'h000000, 2, 8'd3, 2000);
    vecs[2] = mk(24'h000000, 24'h123456, 24'h000000, 24'h000000, 0, 8'd0, 0);
    vecs[3] = mk(24'h111101, 24'h222202, 24'h333303, 24'h444404, 4, 8'd4, 0);
    vecs[4] = mk(24'h000005, 24'h000000, 24'h777777, 24'h000000, 1, 8'd1, 0);
    vecs[5] = mk(24'hFFFF00, 24'h4242AA, 24'hFFFF01, 24'h000000, 1, 8'd3, 0);

    // Reset state
    load_lut(vecs[0].e);
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    chk("rst_devid",  32'(dev_id),   32'h78);
    chk("rst_bytlen", 32'(byte_len), 32'h1);

    for (int i = 0; i < 6; i++) run_case(i, vecs[i]);

    // Busy never rises: timeout after BUSY_TO cycles of pluse
    dead = 1'b1;
    load_lut(vecs[0].e);
    do_reset();
    tp = 0;
    for (int n = 0; n < 2000 && !pluse; n++) @(negedge clk);
    chk("to_pluse_seen", 32'(pluse), 32'h1);
    tp = cyc;
    wait_end("to", 5000);
    te = cyc;
    chk("to_err",    32'(err),       32'h1);
    chk("to_done",   32'(done),      32'h0);
    chk("to_errix",  32'(err_index), 32'h0);
    chk("to_pluse",  32'(pluse),     32'h0);
    chk("to_time",   32'((te - tp >= 4095) && (te - tp <= 4098)), 32'h1);
    dead = 1'b0;

    // Reset for one cycle while waiting for entry 1 to finish
    load_lut(vecs[0].e);
    do_reset();
    for (int n = 0; n < 3000 && !(lut_index == 8'd1 && busy && !pluse); n++) @(negedge clk);
    chk("mr_in_waitl", 32'(lut_index == 8'd1 && busy && !pluse), 32'h1);
    rstn = 1'b0;
    @(negedge clk);
    chk_reset_vals("mr");
    rstn = 1'b1;
    wait_end("mr", 8000);
    chk("mr_done", 32'(done), 32'h1);
    chk("mr_idx",  32'(lut_index), 32'h2);

    // start during S_TRIG is ignored; start after done replays the table
    load_lut(vecs[0].e);
    do_reset();
    wb = wq_addr.size();
    for (int n = 0; n < 2000 && !pluse; n++) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_end("st1", 8000);
    chk("st1_done", 32'(done), 32'h1);
    chk("st1_nwr",  32'(wq_addr.size() - wb), 32'h2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("st2_left_done", 32'(done), 32'h0);
    wait_end("st2", 8000);
    chk("st2_done", 32'(done), 32'h1);
    chk("st2_nwr",  32'(wq_addr.size() - wb), 32'h4);
    if (wq_addr.size() >= 2) begin
      chk("st2_last_addr", 32'(wq_addr[wq_addr.size()-1]), 32'h3103);
      chk("st2_last_data", 32'(wq_data[wq_data.size()-1]), 32'h03);
    end

`ifdef IIC_CFG_READBACK_EN
    // Slave returns wrong data for 0x3103
    bad_en = 1'b1;
    load_lut(vecs[0].e);
    do_reset();
    wait_end("rb", 8000);
    chk("rb_err",   32'(err),       32'h1);
    chk("rb_errix", 32'(err_index), 32'h1);
    bad_en = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
